// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache refill controller:
//   - refill_state_t : refill sequencer states
//   - DEF_*          : default bus/line geometry
//   - OFS / IDX_W    : byte-offset bits of a line and word-index width,
//                      derived from the default geometry
//   - calc_ofs       : byte-offset width for an arbitrary geometry
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

  // Number of low address bits covered by one cache line.
  function automatic int calc_ofs(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  localparam int OFS   = calc_ofs(DEF_LINE_WORDS, DEF_DATA_W);
  localparam int IDX_W = $clog2(DEF_LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_if
// Burst-read port between the refill controller and backing memory.
//   mem_req_o    : burst read request (controller -> memory), held until granted
//   mem_addr_o   : line-aligned burst base address (controller -> memory)
//   mem_gnt_i    : memory accepted the request this cycle (memory -> controller)
//   mem_rvalid_i : returned word valid (memory -> controller)
//   mem_rdata_i  : returned word, ascending address order (memory -> controller)
// Modports: master = refill controller, slave = memory side.
// -----------------------------------------------------------------------------
interface icache_refill_ctrl_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Sequences an instruction-cache line refill on a fetch miss: one line-aligned
// burst read, streams returned words into the data array, then pulses the
// tag/valid write. Fetch is stalled for the whole refill.
// Ports:
//   clk_i          : clock, rising edge
//   rst_n_i        : synchronous active-low reset
//   instr_miss_f_i : F-stage lookup missed this cycle
//   miss_addr_i    : byte address of the missing fetch
//   stall_f_o      : stall fetch/PC (combinational with the miss)
//   mem            : burst-read port to backing memory (master side)
//   fill_we_o      : write fill_data_o into the data array
//   fill_idx_o     : word offset within the line being written
//   fill_data_o    : word to write (returned memory data)
//   rep_en_o       : one-cycle tag/valid commit pulse
//   refill_busy_o  : refill in progress
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int LINE_WORDS = DEF_LINE_WORDS,
  localparam int LINE_IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  instr_miss_f_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  output logic                  stall_f_o,
  icache_refill_ctrl_if.master  mem,
  output logic                  fill_we_o,
  output logic [LINE_IDX_W-1:0] fill_idx_o,
  output logic [DATA_W-1:0]     fill_data_o,
  output logic                  rep_en_o,
  output logic                  refill_busy_o
);

  localparam int LINE_OFS = calc_ofs(LINE_WORDS, DATA_W);

  // Clears the byte offset inside a line, giving the burst base address.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'((64'd1 << LINE_OFS) - 64'd1);

  localparam logic [LINE_IDX_W-1:0] LAST_IDX = LINE_IDX_W'(LINE_WORDS - 1);

  refill_state_t           r_state;
  refill_state_t           w_state_next;
  logic [LINE_IDX_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]       r_line_addr;
  logic                    w_accept;
  logic                    w_last;

  // A word is taken in FILL, or in REQ when data arrives together with the
  // grant (it is then word 0). Any other rvalid is stray and dropped.
  assign w_accept = mem.mem_rvalid_i &
                    ((r_state == FILL) | ((r_state == REQ) & mem.mem_gnt_i));
  assign w_last   = w_accept & (r_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (instr_miss_f_i) w_state_next = REQ;
      REQ:  if (mem.mem_gnt_i)  w_state_next = FILL;
      FILL: if (w_last)         w_state_next = DONE;
      DONE:                     w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Word counter and captured line address
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt       <= '0;
      r_line_addr <= '0;
    end else begin
      // Address is captured only on the miss cycle; later miss_addr_i
      // changes cannot disturb an active burst.
      if ((r_state == IDLE) && instr_miss_f_i) begin
        r_line_addr <= miss_addr_i & LINE_MASK;
      end
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Output decode; everything but stall is forced low while idle.
  always_comb begin
    refill_busy_o  = (r_state != IDLE);
    stall_f_o      = instr_miss_f_i | (r_state != IDLE);
    mem.mem_req_o  = (r_state == REQ);
    mem.mem_addr_o = (r_state != IDLE) ? r_line_addr : '0;
    fill_we_o      = w_accept;
    fill_idx_o     = (r_state != IDLE) ? r_cnt : '0;
    fill_data_o    = (r_state != IDLE) ? mem.mem_rdata_i : '0;
    rep_en_o       = (r_state == DONE);
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Directed scenarios plus a randomized run. A transaction-level model (active
// refill, granted flag, words received, line address) predicts every output
// each cycle; directed scenarios additionally pin the model with literal
// expectations (addresses, indices, data, pulse timing).
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam logic [31:0] LINE_BYTES = 32'(LW * DW / 8);

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          instr_miss_f_i = 1'b0;
  logic [AW-1:0] miss_addr_i = '0;
  logic          stall_f_o;
  logic          fill_we_o;
  logic [IW-1:0] fill_idx_o;
  logic [DW-1:0] fill_data_o;
  logic          rep_en_o;
  logic          refill_busy_o;

  icache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  icache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .instr_miss_f_i (instr_miss_f_i),
    .miss_addr_i    (miss_addr_i),
    .stall_f_o      (stall_f_o),
    .mem            (mem_if),
    .fill_we_o      (fill_we_o),
    .fill_idx_o     (fill_idx_o),
    .fill_data_o    (fill_data_o),
    .rep_en_o       (rep_en_o),
    .refill_busy_o  (refill_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Transaction-level model state
  bit          m_active = 1'b0;
  bit          m_granted = 1'b0;
  int          m_words = 0;
  logic [31:0] m_line = '0;

  // Observation log used by the directed literal checks
  int          wq_idx[$];
  logic [31:0] wq_data[$];
  int          rep_cnt = 0;
  int          last_rep_cyc = 0;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] rep_addr = '0;
  int          t0_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // inputs that the next rising edge will sample.
  always @(negedge clk_i) begin
    bit          e_we;
    bit          e_rep;
    bit          e_req;
    logic [31:0] e_addr;
    cyc++;
    e_req  = m_active && !m_granted;
    e_addr = m_active ? m_line : 32'h0;
    e_rep  = m_active && (m_words == LW);
    e_we   = m_active && (m_words < LW) && (m_granted || mem_if.mem_gnt_i)
             && mem_if.mem_rvalid_i;
    if (chk_on) begin
      chk("stall", 64'(stall_f_o), 64'(instr_miss_f_i | m_active));
      chk("busy", 64'(refill_busy_o), 64'(m_active));
      chk("req", 64'(mem_if.mem_req_o), 64'(e_req));
      chk("addr", 64'(mem_if.mem_addr_o), 64'(e_addr));
      chk("we", 64'(fill_we_o), 64'(e_we));
      chk("rep", 64'(rep_en_o), 64'(e_rep));
      if (e_we) begin
        chk("idx", 64'(fill_idx_o), 64'(m_words));
        chk("data", 64'(fill_data_o), 64'(mem_if.mem_rdata_i));
      end
      if (!m_active) begin
        chk("idle_idx", 64'(fill_idx_o), 64'd0);
        chk("idle_data", 64'(fill_data_o), 64'd0);
      end
    end
    if (fill_we_o) begin
      wq_idx.push_back(int'(fill_idx_o));
      wq_data.push_back(fill_data_o);
    end
    if (rep_en_o) begin
      rep_cnt++;
      last_rep_cyc = cyc;
      rep_addr = mem_if.mem_addr_o;
    end
    if (stall_f_o) stall_cnt++;
    if (mem_if.mem_req_o) begin
      req_cnt++;
      last_req_addr = mem_if.mem_addr_o;
    end
    if (!rst_n_i) begin
      m_active = 1'b0; m_granted = 1'b0; m_words = 0; m_line = '0;
    end else if (!m_active) begin
      if (instr_miss_f_i) begin
        m_active = 1'b1; m_granted = 1'b0; m_words = 0;
        m_line = miss_addr_i & ~(LINE_BYTES - 32'd1);
      end
    end else if (m_words == LW) begin
      m_active = 1'b0;
    end else begin
      if (e_we) m_words++;
      if (mem_if.mem_gnt_i) m_granted = 1'b1;
    end
  end

  task automatic drive(input bit rn, input bit m, input logic [31:0] a,
                       input bit g, input bit v, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    rst_n_i = rn;
    instr_miss_f_i = m;
    miss_addr_i = a;
    mem_if.mem_gnt_i = g;
    mem_if.mem_rvalid_i = v;
    mem_if.mem_rdata_i = d;
  endtask

  task automatic settle();
    @(negedge clk_i);
    #1;
  endtask

  // Full refill: miss, gdel un-granted REQ cycles, grant, rvalid pattern
  // (LSB first), DONE, then the hit cycle that drops the miss.
  task automatic refill(input logic [31:0] a, input int gdel, input bit stray,
                        input logic [15:0] pat, input int plen, input logic [31:0] a_during);
    int k;
    drive(1, 1, a, 0, 0, 0);
    t0_cyc = cyc + 1;
    for (int i = 0; i < gdel; i++) drive(1, 1, a_during, 0, stray, 32'hDEAD_0000 + 32'(i));
    drive(1, 1, a_during, 1, 0, 0);
    k = 0;
    for (int i = 0; i < plen; i++) begin
      drive(1, 1, a_during, 0, pat[i], pat[i] ? 32'hA000_0000 + 32'(k) : 32'h0);
      if (pat[i]) k++;
    end
    drive(1, 1, a_during, 0, 0, 0);
    drive(1, 0, a, 0, 0, 0);
    settle();
  endtask

  task automatic check_line(input string nm, input int base);
    chk({nm, "_nwrites"}, 64'(wq_idx.size() - base), 64'(LW));
    if (wq_idx.size() >= base + LW) begin
      for (int k = 0; k < LW; k++) begin
        chk({nm, "_idx"}, 64'(wq_idx[base + k]), 64'(k));
        chk({nm, "_data"}, 64'(wq_data[base + k]), 64'(32'hA000_0000 + 32'(k)));
      end
    end
  endtask

  initial begin
    int wb, rb, sb, qb;
    mem_if.mem_gnt_i = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i = '0;

    // Reset held two cycles with miss asserted
    drive(0, 1, 32'h0, 0, 0, 0);
    chk_on = 1'b1;
    drive(0, 1, 32'h0, 0, 0, 0);
    settle();
    chk("rst_stall", 64'(stall_f_o), 64'd1);
    chk("rst_busy", 64'(refill_busy_o), 64'd0);
    chk("rst_req", 64'(mem_if.mem_req_o), 64'd0);
    chk("rst_addr", 64'(mem_if.mem_addr_o), 64'd0);
    chk("rst_we", 64'(fill_we_o), 64'd0);
    chk("rst_rep", 64'(rep_en_o), 64'd0);
    drive(1, 0, 32'h0, 0, 0, 0);
    settle();
    $display("txn reset: stall=%0b busy=%0b", stall_f_o, refill_busy_o);

    // Basic refill at 0x14
    wb = wq_idx.size(); rb = rep_cnt; sb = stall_cnt; qb = req_cnt;
    refill(32'h0000_0014, 0, 0, 16'hF, 4, 32'h0000_0014);
    chk("basic_addr", 64'(last_req_addr), 64'h10);
    chk("basic_reqcyc", 64'(req_cnt - qb), 64'd1);
    check_line("basic", wb);
    chk("basic_rep_cnt", 64'(rep_cnt - rb), 64'd1);
    chk("basic_rep_lat", 64'(last_rep_cyc - t0_cyc), 64'(LW + 2));
    chk("basic_stall_len", 64'(stall_cnt - sb), 64'(LW + 3));
    chk("basic_release", 64'(stall_f_o), 64'd0);
    $display("txn basic: addr=%0h rep_lat=%0d stall=%0d", last_req_addr, last_rep_cyc - t0_cyc, stall_cnt - sb);

    // Late grant with rvalid gaps 1,0,0,1,1,0,1
    wb = wq_idx.size(); rb = rep_cnt; qb = req_cnt;
    refill(32'h0000_1238, 3, 0, 16'h0059, 7, 32'h0000_1238);
    chk("gap_addr", 64'(last_req_addr), 64'h1230);
    chk("gap_reqcyc", 64'(req_cnt - qb), 64'd4);
    check_line("gap", wb);
    chk("gap_rep_cnt", 64'(rep_cnt - rb), 64'd1);
    $display("txn gaps: writes=%0d reps=%0d", wq_idx.size() - wb, rep_cnt - rb);

    // Stray rvalid in IDLE and in REQ before grant
    wb = wq_idx.size();
    drive(1, 0, 32'h0, 0, 1, 32'h5555_5555);
    drive(1, 0, 32'h0, 0, 1, 32'h6666_6666);
    settle();
    chk("stray_idle", 64'(wq_idx.size() - wb), 64'd0);
    refill(32'h0000_0300, 2, 1, 16'hF, 4, 32'h0000_0300);
    check_line("stray", wb);
    $display("txn stray: writes=%0d", wq_idx.size() - wb);

    // Reset in the middle of FILL after two words
    wb = wq_idx.size(); rb = rep_cnt;
    drive(1, 1, 32'h0000_0100, 0, 0, 0);
    drive(1, 1, 32'h0000_0100, 1, 0, 0);
    drive(1, 1, 32'h0000_0100, 0, 1, 32'hA000_0000);
    drive(1, 1, 32'h0000_0100, 0, 1, 32'hA000_0001);
    drive(0, 0, 32'h0000_0100, 0, 0, 0);
    drive(1, 0, 32'h0000_0100, 0, 1, 32'hBAD0_0002);
    drive(1, 0, 32'h0000_0100, 0, 1, 32'hBAD0_0003);
    settle();
    chk("abort_busy", 64'(refill_busy_o), 64'd0);
    chk("abort_writes", 64'(wq_idx.size() - wb), 64'd2);
    chk("abort_rep", 64'(rep_cnt - rb), 64'd0);
    wb = wq_idx.size();
    refill(32'h0000_0040, 0, 0, 16'hF, 4, 32'h0000_0040);
    chk("abort_new_addr", 64'(last_req_addr), 64'h40);
    check_line("abort_new", wb);
    $display("txn abort: new addr=%0h", last_req_addr);

    // miss_addr_i changes during REQ must not move the burst address
    refill(32'h0000_0020, 2, 0, 16'hF, 4, 32'h0000_0080);
    chk("addrchg_req", 64'(last_req_addr), 64'h20);
    chk("addrchg_rep", 64'(rep_addr), 64'h20);
    $display("txn addr change: req=%0h rep=%0h", last_req_addr, rep_addr);

    // Randomized traffic; model checks every cycle
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk_i);
      #1;
      rst_n_i = ($urandom_range(0, 149) != 0);
      instr_miss_f_i = refill_busy_o ? 1'b1 : ($urandom_range(0, 2) == 0);
      miss_addr_i = $urandom;
      mem_if.mem_gnt_i = mem_if.mem_req_o ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 9) == 0);
      mem_if.mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_if.mem_rdata_i = $urandom;
    end
    drive(1, 0, 32'h0, 0, 0, 0);
    settle();
    $display("txn random: reps=%0d writes=%0d", rep_cnt, wq_idx.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
